// File: rtl/keypoint_decode.sv
// Per-cell softmax result to sparse keypoint record converter.
// One registered output stage; every frame ends with exactly one tlast record.
module keypoint_decode #(
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int DUSTBIN_ID = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [15:0] thresh_i,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [12:0] kp_count_o,
  output logic        frame_done_o,
  output logic        err_o
);

  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, cur_col;
  logic [RW-1:0] row_q, cur_row;
  logic [15:0]   thr_q, cur_thr;
  logic [15:0]   prob;
  logic [7:0]    id;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [63:0]   record;
  logic          accept, qualify, is_last;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;

  // The first beat of a frame is cell 0 and uses the live threshold.
  always_comb begin
    prob    = s_axis_tdata[15:0];
    id      = s_axis_tdata[23:16];
    accept  = s_axis_tvalid && s_axis_tready;
    cur_col = (state_q == IDLE) ? '0 : col_q;
    cur_row = (state_q == IDLE) ? '0 : row_q;
    cur_thr = (state_q == IDLE) ? thresh_i : thr_q;
    is_last = (cur_col == CW'(GRID_W - 1)) && (cur_row == RW'(GRID_H - 1));
    qualify = (id < 8'(DUSTBIN_ID)) && (prob >= cur_thr);
    x       = 10'({cur_col, id[2:0]});
    y       = 9'({cur_row, id[5:3]});
    record  = {1'b1, 15'b0, prob, 7'b0, y, 6'b0, x};
    state_d = state_q;
    if (accept) state_d = is_last ? IDLE : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      thr_q         <= '0;
      kp_count_o    <= '0;
      err_o         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      frame_done_o <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (accept) begin
        if (is_last) begin
          col_q <= '0;
          row_q <= '0;
        end else if (cur_col == CW'(GRID_W - 1)) begin
          col_q <= '0;
          row_q <= cur_row + RW'(1);
        end else begin
          col_q <= cur_col + CW'(1);
          row_q <= cur_row;
        end
        if (state_q == IDLE) thr_q <= thresh_i;
        kp_count_o <= ((state_q == IDLE) ? 13'd0 : kp_count_o) + 13'(qualify);
        if (id > 8'(DUSTBIN_ID)) err_o <= 1'b1;
        m_axis_tvalid <= qualify || is_last;
        m_axis_tdata  <= qualify ? record : '0;
        m_axis_tlast  <= is_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
